// File: rtl/mem_request_queue.sv
// mem_request_queue
//   In-order request FIFO that sits between the trace parser and the DRAM
//   command scheduler. Non-NOP requests strobed by the parser are buffered.
//   The oldest one is presented on a valid/ready handshake together with the
//   number of cycles it has been waiting. Requests that arrive while the queue
//   is full are dropped and counted.
// Ports
//   clk, rst_n                clock / async active-low reset
//   in_valid/in_op/in_addr    request from parser; in_ready = !full
//   out_valid/out_op/out_addr head entry to scheduler; out_ready pops it
//   out_age                   cycles since the head became visible
//   count/full/empty          occupancy
//   drop_cnt/overflow         saturating drop counter, sticky drop flag
//   q_state                   debug FSM state (EMPTY/ACTIVE/FULL)

package mem_req_pkg;
  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_READ   = 2'd1,
    OP_WRITE  = 2'd2,
    OP_IFETCH = 2'd3
  } parsed_op_t;
endpackage

module mem_request_queue
  import mem_req_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 33,
  parameter int AGE_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  parsed_op_t               in_op,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     in_ready,
  output logic                     out_valid,
  output parsed_op_t               out_op,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [AGE_W-1:0]         out_age,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  output logic [1:0]               q_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    parsed_op_t        op;
    logic [ADDR_W-1:0] addr;
    logic [AGE_W-1:0]  stamp;
  } entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY  = 2'd0,
    Q_ACTIVE = 2'd1,
    Q_FULL   = 2'd2
  } q_state_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [AGE_W-1:0] stamp;
  q_state_t         state_q, state_d;
  logic             req, enq, deq, drop;

  // Handshake decode. Full/empty come from count so pointer wrap is harmless.
  assign req       = in_valid && (in_op != OP_NOP);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign enq       = req && in_ready;
  assign drop      = req && !in_ready;
  assign out_valid = !empty;
  assign deq       = out_valid && out_ready;

  // Head presentation; forced to idle values when nothing is queued so the
  // uninitialised storage never leaks out.
  assign head     = mem[rd_ptr];
  assign out_op   = empty ? OP_NOP : head.op;
  assign out_addr = empty ? '0 : head.addr;
  assign out_age  = empty ? '0 : AGE_W'(stamp - head.stamp);
  assign q_state  = state_q;

  // Storage is deliberately not reset. The stamp written is the value the
  // counter will hold on the first cycle the entry is visible, so a freshly
  // enqueued head reports age 0.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{op: in_op, addr: in_addr, stamp: stamp + AGE_W'(1)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stamp    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      state_q  <= Q_EMPTY;
    end else begin
      stamp   <= stamp + AGE_W'(1);
      state_q <= state_d;
      count   <= count + CW'(enq) - CW'(deq);
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // Debug FSM: tracks the occupancy class of the next count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Q_EMPTY:  if (enq) state_d = Q_ACTIVE;
      Q_ACTIVE: begin
        if (deq && !enq && count == CW'(1))             state_d = Q_EMPTY;
        else if (enq && !deq && count == CW'(DEPTH - 1)) state_d = Q_FULL;
      end
      Q_FULL:   if (deq) state_d = Q_ACTIVE;
      default:  state_d = Q_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_mem_request_queue.sv
module tb_mem_request_queue;
  import mem_req_pkg::*;

  localparam int DEPTH = 16;

  logic        clk, rst_n;
  logic        in_valid, out_ready;
  parsed_op_t  in_op;
  logic [32:0] in_addr;
  logic        in_ready, out_valid, full, empty, overflow;
  parsed_op_t  out_op;
  logic [32:0] out_addr;
  logic [15:0] out_age;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;
  logic [1:0]  q_state;

  mem_request_queue #(.DEPTH(DEPTH), .ADDR_W(33), .AGE_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr), .in_ready(in_ready),
    .out_valid(out_valid), .out_op(out_op), .out_addr(out_addr), .out_age(out_age),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .overflow(overflow), .q_state(q_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of requests, each tagged with the clock edge
  // number at which it was accepted.
  typedef struct {
    parsed_op_t  op;
    logic [32:0] addr;
    int          edge_no;
  } ment_t;

  ment_t mq[$];
  int    m_edge;
  int    m_drops;
  bit    m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_edge  = 0;
      m_drops = 0;
      m_ovf   = 0;
    end else begin
      bit is_req, pop, push;
      ment_t e;
      m_edge++;
      is_req = in_valid && (in_op != OP_NOP);
      pop    = (mq.size() > 0) && out_ready;
      push   = is_req && (mq.size() < DEPTH);
      if (is_req && mq.size() == DEPTH) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.op = in_op; e.addr = in_addr; e.edge_no = m_edge;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      n = mq.size();
      chk("count", 64'(count), 64'(n));
      chk("full", 64'(full), 64'(n == DEPTH));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(n != 0));
      chk("q_state", 64'(q_state), 64'((n == 0) ? 0 : (n == DEPTH) ? 2 : 1));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (n == 0) begin
        chk("out_op", 64'(out_op), 64'(OP_NOP));
        chk("out_addr", 64'(out_addr), 64'd0);
        chk("out_age", 64'(out_age), 64'd0);
      end else begin
        chk("out_op", 64'(out_op), 64'(mq[0].op));
        chk("out_addr", 64'(out_addr), 64'(mq[0].addr));
        chk("out_age", 64'(out_age), 64'((m_edge - mq[0].edge_no) & 16'hFFFF));
      end
    end
  end

  // Apply inputs, let one clock edge consume them, return 1 time unit later.
  task automatic cyc(input logic v, input parsed_op_t op, input logic [32:0] a, input logic r);
    in_valid = v; in_op = op; in_addr = a; out_ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst count", 64'(count), 64'd0);
    chk("rst empty", 64'(empty), 64'd1);
    chk("rst full", 64'(full), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_op", 64'(out_op), 64'(OP_NOP));
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst q_state", 64'(q_state), 64'd0);

    // Single READ, visible one cycle later with age 0
    cyc(0, OP_NOP, '0, 0);
    cyc(0, OP_NOP, '0, 0);
    cyc(1, OP_READ, 33'h1F4, 0);
    chk("t1 out_valid", 64'(out_valid), 64'd1);
    chk("t1 out_op", 64'(out_op), 64'(OP_READ));
    chk("t1 out_addr", 64'(out_addr), 64'h1F4);
    chk("t1 count", 64'(count), 64'd1);
    chk("t1 out_age", 64'(out_age), 64'd0);
    cyc(0, OP_NOP, '0, 1);

    // Fill to 16, then one dropped request
    for (int i = 0; i < 16; i++) cyc(1, OP_WRITE, 33'(32'h100 + i), 0);
    chk("t2 full", 64'(full), 64'd1);
    chk("t2 in_ready", 64'(in_ready), 64'd0);
    chk("t2 q_state", 64'(q_state), 64'd2);
    cyc(1, OP_WRITE, 33'h999, 0);
    chk("t2 drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t2 overflow", 64'(overflow), 64'd1);
    chk("t2 count", 64'(count), 64'd16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      chk("t3 pop addr", 64'(out_addr), 64'(32'h100 + i));
      cyc(0, OP_NOP, '0, 1);
    end
    chk("t3 empty", 64'(empty), 64'd1);
    chk("t3 q_state", 64'(q_state), 64'd0);
    chk("t3 out_op", 64'(out_op), 64'(OP_NOP));

    // Hold count at 5 with simultaneous push/pop across the pointer wrap
    for (int i = 0; i < 5; i++) cyc(1, OP_IFETCH, 33'(32'h400 + i), 0);
    for (int j = 0; j < 12; j++) begin
      cyc(1, OP_READ, 33'(32'h500 + j), 1);
      chk("t4 count", 64'(count), 64'd5);
    end
    chk("t4 head", 64'(out_addr), 64'h507);
    for (int i = 0; i < 5; i++) cyc(0, OP_NOP, '0, 1);

    // NOP filter
    for (int i = 0; i < 10; i++) cyc(1, OP_NOP, 33'h123, 0);
    chk("t5 count", 64'(count), 64'd0);
    chk("t5 drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t5 in_ready", 64'(in_ready), 64'd1);

    // Drop counter saturation
    for (int i = 0; i < 16; i++) cyc(1, OP_WRITE, 33'(32'h600 + i), 0);
    for (int i = 0; i < 260; i++) cyc(1, OP_READ, 33'h1_0000_0000, 0);
    chk("sat drop_cnt", 64'(drop_cnt), 64'd255);
    // Full with out_ready: pops but still refuses the new request
    cyc(1, OP_READ, 33'h777, 1);
    chk("full pass count", 64'(count), 64'd15);
    for (int i = 0; i < 15; i++) cyc(0, OP_NOP, '0, 1);

    // Age accumulation, then asynchronous reset mid-cycle
    cyc(1, OP_READ, 33'hA0, 0);
    cyc(1, OP_WRITE, 33'hA1, 0);
    cyc(1, OP_IFETCH, 33'hA2, 0);
    for (int i = 0; i < 40; i++) cyc(0, OP_NOP, '0, 0);
    chk("t6 out_age", 64'(out_age), 64'd42);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async out_valid", 64'(out_valid), 64'd0);
    chk("t6 async count", 64'(count), 64'd0);
    chk("t6 async overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1, OP_WRITE, 33'h55, 0);
    chk("post rst addr", 64'(out_addr), 64'h55);
    cyc(0, OP_NOP, '0, 1);
    cyc(0, OP_NOP, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
